// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/stall controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_STALL = 2'd1,
    MDU_BUSY   = 2'd2
  } state_t;

  // Control vector packing: {pcWrite, IF_ID_write, controlSel, IF_ID_flush}
  localparam logic [3:0] CTRL_STALL   = 4'b0000;
  localparam logic [3:0] CTRL_RELEASE = 4'b1110;
  localparam logic [3:0] CTRL_FLUSH   = 4'b1101;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous reset, enable, and saturation at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Count enabled cycles, sticking at the maximum instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline front-end stall controller: load-use, MDU busy and taken-branch flush.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W         = 5,
  parameter int LOAD_LAT      = 1,
  parameter int MDU_LAT       = 4,
  parameter int STAT_W        = 16,
  parameter int ZERO_REG_SKIP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ID_EX_memRead,
  input  logic [REG_W-1:0]  ID_EX_Rt,
  input  logic [REG_W-1:0]  Rs,
  input  logic [REG_W-1:0]  Rt,
  input  logic              ID_usesRt,
  input  logic              mduStart,
  input  logic              branchTaken,
  output logic              pcWrite,
  output logic              IF_ID_write,
  output logic              controlSel,
  output logic              IF_ID_flush,
  output logic              mduBusy,
  output logic [STAT_W-1:0] stallCycles
);

  localparam int CNT_W = $clog2(maxInt(LOAD_LAT, MDU_LAT)) + 1;

  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LOAD_INIT = CNT_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] MDU_INIT  = CNT_W'(MDU_LAT - 1);
  localparam logic             SKIP_ZERO = (ZERO_REG_SKIP != 0);
  localparam logic             MULTI_LOAD = (LOAD_LAT > 1);

  state_t           state;
  state_t           nextState;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nextCnt;
  logic [3:0]       ctrl;
  logic             hz;

  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  // Register 0 is hard-wired, so a load targeting it can optionally be ignored.
  assign hz = ID_EX_memRead
            & ~(SKIP_ZERO & (ID_EX_Rt == '0))
            & ((ID_EX_Rt == Rs) | (ID_usesRt & (ID_EX_Rt == Rt)));

  // State and remaining-stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  // Next state and front-end control; reset forces a release with the FSM idle
  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    ctrl      = CTRL_RELEASE;
    mduBusy   = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (branchTaken) begin
            ctrl = CTRL_FLUSH;
          end else if (mduStart) begin
            ctrl      = CTRL_STALL;
            nextState = MDU_BUSY;
            nextCnt   = MDU_INIT;
          end else if (hz) begin
            ctrl = CTRL_STALL;
            if (MULTI_LOAD) begin
              nextState = LOAD_STALL;
              nextCnt   = LOAD_INIT;
            end
          end
        end
        LOAD_STALL: begin
          if (branchTaken) begin
            // The stalled instruction is on the wrong path; drop the stall
            ctrl      = CTRL_FLUSH;
            nextState = IDLE;
            nextCnt   = '0;
          end else begin
            ctrl    = CTRL_STALL;
            nextCnt = cnt - CNT_ONE;
            if (cnt == CNT_ONE) nextState = IDLE;
          end
        end
        MDU_BUSY: begin
          ctrl    = CTRL_STALL;
          mduBusy = 1'b1;
          nextCnt = cnt - CNT_ONE;
          if (cnt == CNT_ONE) nextState = IDLE;
        end
        default: begin
          nextState = IDLE;
          nextCnt   = '0;
        end
      endcase
    end
  end

  assign {pcWrite, IF_ID_write, controlSel, IF_ID_flush} = ctrl;

  sat_counter #(
    .WIDTH (STAT_W)
  ) uStallCnt (
    .clk   (clk),
    .rst   (rst),
    .en    (~pcWrite),
    .count (stallCycles)
  );

endmodule
